// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system bus arbiter.
// Provides the FSM state encoding, parameter defaults and an index-width helper.
package sys_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_NUM_MASTERS    = 3;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // clog2 that never returns less than 1, so single-value ranges still get a bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr, wrapping.
// Doubling the request vector turns the wrap-around search into one linear priority encode.
module rr_priority_picker
  import sys_bus_pkg::*;
#(
  parameter int N = DEF_NUM_MASTERS,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_ptr,
  output logic [IW-1:0] o_winner,
  output logic          o_found
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    w_dbl    = {i_req, i_req};
    w_masked = '0;
    o_winner = '0;
    o_found  = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      w_masked[i] = w_dbl[i] & (i >= int'(i_rr_ptr));
    end
    // Scan downward so the lowest qualifying bit is the last one written.
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        o_winner = IW'(i % N);
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin system bus arbiter with one-hot registered grants and a watchdog.
// An owner keeps the bus until txn_done, request withdrawal or watchdog expiry.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_MASTERS-1:0]              m_req,
  input  logic                                txn_done,
  output logic [NUM_MASTERS-1:0]              m_grant,
  output logic [idx_width(NUM_MASTERS)-1:0]   grant_idx,
  output logic                                bus_busy,
  output logic                                timeout_err
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam int WW = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = '1;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_idx;
  logic                   r_busy;
  logic                   r_timeout;
  logic [IW-1:0]          r_rr_ptr;
  logic [WW-1:0]          r_wd_cnt;

  logic [IW-1:0]          w_winner;
  logic                   w_found;
  logic [IW-1:0]          w_next_ptr;
  logic [NUM_MASTERS-1:0] w_onehot;
  logic                   w_owner_req;
  logic                   w_wd_expire;
  logic                   w_release;
  logic                   w_timeout_fire;

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .i_req    (m_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  always_comb begin
    w_next_ptr     = (int'(w_winner) == NUM_MASTERS - 1) ? '0 : w_winner + IW'(1);
    w_onehot       = NUM_MASTERS'(1) << w_winner;
    w_owner_req    = m_req[r_idx];
    w_wd_expire    = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST);
    // txn_done and withdrawal outrank the watchdog, so they suppress the error pulse.
    w_release      = txn_done || !w_owner_req || w_wd_expire;
    w_timeout_fire = !txn_done && w_owner_req && w_wd_expire;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_rr_ptr  <= '0;
      r_wd_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= ACTIVE;
            r_grant  <= w_onehot;
            r_idx    <= w_winner;
            r_busy   <= 1'b1;
            r_wd_cnt <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        ACTIVE: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= w_timeout_fire;
          end else if (r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + WW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_grant     = r_grant;
  assign grant_idx   = r_idx;
  assign bus_busy    = r_busy;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against an ownership-level reference model.
module tb_sys_bus_arbiter;
  import sys_bus_pkg::*;

  localparam int N  = 3;
  localparam int T  = 4;
  localparam int IW = idx_width(N);

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  m_req;
  logic          txn_done;
  logic [N-1:0]  m_grant;
  logic [IW-1:0] grant_idx;
  logic          bus_busy;
  logic          timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: who owns the bus, next search start, cycles owned, error pulse.
  int mdl_owner;
  int mdl_ptr;
  int mdl_age;
  bit mdl_to;

  always #5 clk = ~clk;

  sys_bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m_req       (m_req),
    .txn_done    (txn_done),
    .m_grant     (m_grant),
    .grant_idx   (grant_idx),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_ptr   = 0;
    mdl_age   = 0;
    mdl_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic done);
    mdl_to = 1'b0;
    if (mdl_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (req[c]) begin
          mdl_owner = c;
          mdl_age   = 0;
          mdl_ptr   = (c + 1) % N;
          break;
        end
      end
    end else if (done || !req[mdl_owner]) begin
      mdl_owner = -1;
    end else if (mdl_age == T - 1) begin
      mdl_owner = -1;
      mdl_to    = 1'b1;
    end else begin
      mdl_age++;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_grant;
    logic [31:0] e_idx;
    e_grant = (mdl_owner >= 0) ? (32'd1 << mdl_owner) : 32'd0;
    e_idx   = (mdl_owner >= 0) ? 32'(mdl_owner) : 32'd0;
    check("grant", 32'(m_grant), e_grant);
    check("grant_idx", 32'(grant_idx), e_idx);
    check("bus_busy", 32'(bus_busy), 32'(mdl_owner >= 0));
    check("timeout_err", 32'(timeout_err), 32'(mdl_to));
    check("grant_onehot0", 32'($onehot0(m_grant)), 32'd1);
  endtask

  // Drive one cycle of inputs from the falling edge, step the model on the
  // rising edge, then sample the DUT on the next falling edge.
  task automatic cycle(input logic [N-1:0] req, input logic done);
    m_req    = req;
    txn_done = done;
    @(posedge clk);
    model_step(req, done);
    @(negedge clk);
    txn_done = 1'b0;
    check_outputs();
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    rstn     = 1'b0;
    m_req    = '0;
    txn_done = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] grant_seq[$];
    logic [N-1:0] exp_seq[4];
    logic [N-1:0] rnd_req;
    int held;
    int run;
    int first_run;

    rstn     = 1'b0;
    m_req    = '0;
    txn_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rstn = 1'b1;

    // Single request, grant next cycle, release on txn_done.
    cycle(3'b000, 1'b0);
    cycle(3'b010, 1'b0);
    check("t1_grant", 32'(m_grant), 32'b010);
    check("t1_idx", 32'(grant_idx), 32'd1);
    cycle(3'b010, 1'b0);
    cycle(3'b010, 1'b0);
    cycle(3'b010, 1'b1);
    check("t1_release", 32'(m_grant), 32'd0);

    // All masters requesting: rotation 0,1,2,0 with txn_done two cycles after each grant.
    do_reset();
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    held = 0;
    for (int i = 0; i < 40 && grant_seq.size() < 4; i++) begin
      cycle(3'b111, (held == 2));
      if (mdl_owner >= 0) held++;
      else held = 0;
      if (held == 1) grant_seq.push_back(m_grant);
    end
    check("t2_grant_count", 32'(grant_seq.size()), 32'd4);
    for (int i = 0; i < grant_seq.size() && i < 4; i++) begin
      check("t2_grant_order", 32'(grant_seq[i]), 32'(exp_seq[i]));
    end

    // Watchdog: grant held exactly T cycles, error pulse on release, then regrant.
    do_reset();
    run = 0;
    first_run = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(3'b001, 1'b0);
      if (m_grant == 3'b001) begin
        run++;
      end else if (run > 0 && first_run < 0) begin
        first_run = run;
        check("t3_err_on_release", 32'(timeout_err), 32'd1);
      end
    end
    check("t3_grant_cycles", 32'(first_run), 32'(T));

    // txn_done in the watchdog expiry cycle wins: no error.
    do_reset();
    repeat (4) cycle(3'b001, 1'b0);
    cycle(3'b001, 1'b1);
    check("t4_released", 32'(m_grant), 32'd0);
    check("t4_no_err", 32'(timeout_err), 32'd0);

    // Owner withdraws; pointer wrapped to 0 so master 0 wins next.
    do_reset();
    cycle(3'b100, 1'b0);
    check("t5_grant2", 32'(m_grant), 32'b100);
    cycle(3'b100, 1'b0);
    cycle(3'b000, 1'b0);
    check("t5_released", 32'(m_grant), 32'd0);
    check("t5_no_err", 32'(timeout_err), 32'd0);
    cycle(3'b111, 1'b0);
    check("t5_master0", 32'(m_grant), 32'b001);

    // Reset mid-ACTIVE clears the pointer: master 1 beats master 2.
    do_reset();
    cycle(3'b010, 1'b0);
    cycle(3'b010, 1'b0);
    check("t6_busy_before_rst", 32'(bus_busy), 32'd1);
    do_reset();
    cycle(3'b110, 1'b0);
    check("t6_master1", 32'(m_grant), 32'b010);

    // Random traffic against the model.
    do_reset();
    rnd_req = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = N'($urandom);
      cycle(rnd_req, ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares the single system bus between NUM_MASTERS bus masters, e.g. local masters and the bus-bridge master whose addresses are already converted to bus form.
- Round-robin arbitration with one-hot registered grants.
- Holds the grant until the transaction completes, the owner withdraws its request, or a watchdog timeout fires.
- Sits between the masters' request lines and the bus mux and slave select.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255, maximum ACTIVE cycles without txn_done before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master bus request, level, held until served.
- txn_done  in  1  one-cycle pulse from the slave side marking the end of the owner's transaction.
- m_grant  out  NUM_MASTERS  one-hot grant, registered; all-zero when no owner.
- grant_idx  out  clog2(NUM_MASTERS)  binary index of the current owner; valid only while bus_busy.
- bus_busy  out  1  high while state is ACTIVE.
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - m_grant=0, grant_idx=0, bus_busy=0, timeout_err=0.
  - rr_ptr=0, wd_cnt=0, state=IDLE.
- States: IDLE, ACTIVE.
- IDLE:
  - Each cycle, evaluate m_req.
  - If any bit is set, pick the first set bit at or after rr_ptr, searching upward and wrapping.
  - On the next edge: m_grant=onehot(winner), grant_idx=winner, bus_busy=1, wd_cnt=0, rr_ptr=(winner+1) mod NUM_MASTERS, state=ACTIVE.
  - Latency: request seen in cycle t gives grant high in cycle t+1.
  - If no request, stay in IDLE with all outputs 0.
- ACTIVE, evaluated each edge in priority order:
  1. txn_done=1: release. Go to IDLE, m_grant=0, bus_busy=0; timeout_err stays 0 even if the watchdog would expire in the same cycle.
  2. m_req[grant_idx]=0 (owner withdrew): release to IDLE, no error.
  3. TIMEOUT_CYCLES!=0 and wd_cnt==TIMEOUT_CYCLES-1: release to IDLE and pulse timeout_err=1 for exactly one cycle.
  4. Otherwise wd_cnt increments, saturating.
- Release always produces one dead cycle (IDLE, grant all-zero) before the next grant. Grant ownership therefore never switches masters back-to-back.
- Requests from non-owners during ACTIVE are ignored and not latched; they are re-evaluated in IDLE.
- rr_ptr wraps from NUM_MASTERS-1 to 0.
- With all masters requesting continuously, the grant order is 0,1,2,0,...
- A txn_done pulse while IDLE is ignored.
- wd_cnt width is clog2(TIMEOUT_CYCLES+1); the counter never wraps.
- Reset asserted mid-ACTIVE: grant drops immediately (asynchronously) and the bus is released with no timeout_err.
- Invariants:
  - m_grant is one-hot or zero at all times.
  - bus_busy == |m_grant.

Decomposition:
- Shared package sys_bus_pkg:
  - state enum {IDLE, ACTIVE}.
  - Default NUM_MASTERS and TIMEOUT_CYCLES constants.
  - A helper function for index width (clog2 with a minimum of 1).
- One combinational sub-module, rr_priority_picker:
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index and a found flag.
  - Implemented as a double-width masked priority encode.
- The arbiter holds the FSM, watchdog and registered outputs.

Test Plan:
- Reset, then m_req=3'b010 at cycle 2 -> m_grant=3'b010, grant_idx=1, bus_busy=1 in cycle 3; txn_done in cycle 6 -> grant 0 in cycle 7.
- m_req=3'b111 held, txn_done pulsed 2 cycles after each grant -> grant sequence 001,010,100,001, each separated by one all-zero cycle.
- TIMEOUT_CYCLES=4, m_req=3'b001 held, no txn_done -> grant high for exactly 4 cycles, timeout_err one-cycle pulse on the release edge, master 0 regranted after the dead cycle.
- txn_done coincident with the watchdog expiry cycle -> release with timeout_err=0.
- Owner drops m_req mid-ACTIVE (master 2 granted, m_req 100->000) -> grant 0 next cycle, no timeout_err, rr_ptr=0 so master 0 wins the next contest.
- rstn low mid-ACTIVE -> m_grant, bus_busy, timeout_err 0 asynchronously; after release, m_req=3'b110 -> master 1 granted (rr_ptr reset to 0).
